// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder; ovf only with SERIAL_ADDER_OVF_EN.
// Latency n/a (wires only); backpressure carried by in_ready/out_ready.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
`ifdef SERIAL_ADDER_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, out_sum, out_cout
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
`ifdef SERIAL_ADDER_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, out_sum, out_cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder; optional ovf output with SERIAL_ADDER_OVF_EN.
// Latency WIDTH+1 cycles accept->out_valid; result held in DONE until out_ready.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  serial_adder_if.slave  bus,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int            CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Returns {carry_out, sum} for one bit slice.
  function automatic logic [1:0] full_adder(input logic in1, input logic in2, input logic cin);
    logic s;
    logic co;
    s  = in1 ^ in2 ^ cin;
    co = (in1 & in2) | (in1 & cin) | (in2 & cin);
    return {co, s};
  endfunction

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              c_q, c_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        fa;
`ifdef SERIAL_ADDER_OVF_EN
  logic              ovf_q, ovf_d;
`endif

  assign fa = full_adder(a_q[0], b_q[0], c_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          c_d     = bus.in_cin;
          sum_d   = '0;
          cnt_d   = '0;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        c_d   = fa[1];
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        sum_d = {fa[0], sum_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
`ifdef SERIAL_ADDER_OVF_EN
          // c_q here is the carry into the MSB, fa[1] the carry out of it.
          ovf_d   = c_q ^ fa[1];
`endif
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign busy          = (state_q != IDLE);
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = c_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed corner cases then random traffic with stalls.
module tb_serial_adder;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(W)) bus();

  serial_adder #(.WIDTH(W)) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .bus      (bus),
    .busy     (busy)
  );

  int checks = 0;
  int errors = 0;

  logic [W:0] exp_q[$];
  logic       exp_ovf_q[$];
  int         acc_q[$];
  int         cyc = 0;

  bit rdy_rand  = 1'b0;
  bit rdy_force = 1'b1;

  logic         hold = 1'b0;
  logic         prev_vld = 1'b0;
  logic [W-1:0] prev_sum;
  logic         prev_cout;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // out_ready driver: random when enabled, else the directed value.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  // Monitor: handshake bookkeeping, latency, stability and result checks.
  always @(negedge clk) begin
    logic [W:0] e;
    logic       eo;
    int         a;
    cyc++;
    if (!rst_n) begin
      hold     = 1'b0;
      prev_vld = 1'b0;
    end else begin
      check("ready_vs_busy", bus.in_ready, !busy);
      if (hold) begin
        check("hold_valid", bus.out_valid, 1'b1);
        check("hold_sum", bus.out_sum, prev_sum);
        check("hold_cout", bus.out_cout, prev_cout);
      end
      if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
      if (bus.out_valid && !prev_vld) begin
        if (acc_q.size() == 0) check("unexpected_valid", 1, 0);
        else begin
          a = acc_q.pop_front();
          check("latency", cyc - a, W + 1);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("spurious_result", 1, 0);
        else begin
          e  = exp_q.pop_front();
          eo = exp_ovf_q.pop_front();
          check("sum", bus.out_sum, e[W-1:0]);
          check("cout", bus.out_cout, e[W]);
`ifdef SERIAL_ADDER_OVF_EN
          check("ovf", bus.ovf, eo);
`else
          if (eo === 1'bx) check("ovf_model", eo, 0);
`endif
        end
      end
      hold      = bus.out_valid && !bus.out_ready;
      prev_sum  = bus.out_sum;
      prev_cout = bus.out_cout;
      prev_vld  = bus.out_valid;
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    int n = 0;
    logic [W:0] s;
    @(posedge clk); #1;
    while (!bus.in_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 0, 1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    @(posedge clk);
    s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    exp_q.push_back(s);
    exp_ovf_q.push_back((a[W-1] == b[W-1]) && (s[W-1] != a[W-1]));
    #1;
    bus.in_valid = 1'b0;
    bus.in_a     = W'($urandom);
    bus.in_b     = W'($urandom);
    bus.in_cin   = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.in_cin   = 1'b0;

    #12;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", bus.out_sum, 0);
    check("rst_cout", bus.out_cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", bus.ovf, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    send(8'hFF, 8'h01, 1'b0);
    drain();
    send(8'h7F, 8'h01, 1'b0);
    drain();

    // Stall in DONE for 5 cycles.
    rdy_force = 1'b0;
    @(posedge clk); #1;
    send(8'h00, 8'h00, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("stall_reach_done", bus.out_valid, 1);
    repeat (5) begin
      @(posedge clk); #1;
      check("stall_in_ready", bus.in_ready, 0);
      check("stall_valid", bus.out_valid, 1);
      check("stall_sum", bus.out_sum, 8'h01);
    end
    rdy_force = 1'b1;
    @(posedge clk); #1;
    check("idle_after_take", bus.in_ready, 1);
    drain();

    // Operand pulse during RUN must be ignored.
    send(8'h12, 8'h34, 1'b0);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_a     = 8'hAA;
    bus.in_b     = 8'h55;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    drain();
    check("no_extra_accept", acc_q.size(), 0);

    // Reset while processing bit 3.
    send(8'h55, 8'h11, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_sum", bus.out_sum, 0);
    exp_q.delete();
    exp_ovf_q.delete();
    acc_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(8'h05, 8'h03, 1'b0);
    drain();

    rdy_rand = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
